special_merge: RTL
==================

SPECIAL_MERGE -- requirements
Module: special_merge

Interface
REQ-001 SHALL have parameter FILTER_WIDTH, default 8, filter element width; packet width 5*FILTER_WIDTH; legal range 6..16.
REQ-002 SHALL have parameter IFMAP_PER_FILTER, default 16, ifmap packets emitted per filter set; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have ports frow1..frow5 _valid/_ready/_data, in/out/in, 1/1/5*FILTER_WIDTH bits; filter row 1..5 channels.
REQ-006 SHALL have ports ifmap_valid, in, 1; ifmap_ready, out, 1; ifmap_data, in, 25 bits; ifmap_conv_loc, in, 5*FILTER_WIDTH-27 bits; ifmap_size, in, 2 bits; one ifmap channel.
REQ-007 SHALL have ports out_valid, out, 1; out_ready, in, 1; out_data, out, 5*FILTER_WIDTH; out_ifmapb_filter, out, 1; out_filter_row, out, 3 bits; merged packet channel.

Function
REQ-008 A transfer on any channel SHALL occur in a cycle where valid and ready are both 1; valid, once high, SHALL hold with stable payload until the transfer.
REQ-009 FSM states: S_FILTER (accepting filter row row_idx), S_IFMAP (accepting ifmap packets).
REQ-010 In S_FILTER only frow<row_idx>_ready MAY be 1; all other frowN_ready and ifmap_ready SHALL be 0; out-of-order rows wait, never dropped.
REQ-011 In S_IFMAP all frowN_ready SHALL be 0; only ifmap_ready MAY be 1.
REQ-012 Accepted filter row k SHALL produce out_data = row data, out_ifmapb_filter = 1, out_filter_row = k (3'b001..3'b101).
REQ-013 Accepted ifmap SHALL produce out_data = {ifmap_data, ifmap_conv_loc, ifmap_size} (ifmap_data in MSBs, size in [1:0]), out_ifmapb_filter = 0, out_filter_row = 3'b000.
REQ-014 row_idx SHALL increment 1->5 on each filter acceptance; acceptance of row 5 SHALL set state S_IFMAP, row_idx = 1, ifmap_cnt = 0.
REQ-015 ifmap_cnt SHALL increment on each ifmap acceptance; acceptance with ifmap_cnt == IFMAP_PER_FILTER-1 SHALL set state S_FILTER, ifmap_cnt = 0.
REQ-016 Output SHALL be a one-entry register: input accepted in cycle N appears with out_valid = 1 in cycle N+1 (latency 1).
REQ-017 Input ready SHALL be asserted (per REQ-010/011) iff out register empty or out_ready = 1 in the same cycle; full throughput of one packet/cycle with out_ready held 1.
REQ-018 Simultaneous drain and accept SHALL replace the register contents with no bubble; out_valid stays 1.
REQ-019 out_ready = 0 with out_valid = 1 SHALL hold all out_* stable and block all inputs.
REQ-020 No combinational path SHALL exist from any input valid to the same channel's ready.

Reset
REQ-021 rst_n = 0 at a clock edge SHALL set state S_FILTER, row_idx = 1, ifmap_cnt = 0, out_valid = 0, out_data = 0, out_ifmapb_filter = 0, out_filter_row = 0.
REQ-022 While rst_n = 0 all input ready outputs SHALL be 0.
REQ-023 Reset mid-operation SHALL discard any held output packet and any partial filter set; sequencing restarts at row 1.

Structure
REQ-024 Package special_pkg SHALL hold the state enum, ROW_NONE = 3'b000, ROW_FIRST = 3'b001, ROW_LAST = 3'b101.
REQ-025 Output register with valid/ready SHALL be sub-module pkt_out_reg (parameterised width 5*FILTER_WIDTH+4); FSM and mux stay in special_merge.

Verification
REQ-026 Reset, then rows 1..5 = 40'h11..., 40'h22..., ..., 40'h55... with out_ready = 1 -> five outputs, ifmapb_filter = 1, filter_row 1..5, consecutive cycles.
REQ-027 Row 3 and row 2 both valid after row 1 -> row 2 emitted first, row 3 next; ifmap_valid held meanwhile sees ready = 0.
REQ-028 IFMAP_PER_FILTER = 2, after filter set: ifmap 25'h1ABCDEF, conv_loc 13'h0F0, size 2'b10 -> out_data = {25'h1ABCDEF,13'h0F0,2'b10}, filter_row 0; second ifmap accepted, third blocked until new row 1 accepted.
REQ-029 out_ready = 0 for 4 cycles with out_valid = 1 -> out_* stable, all ready = 0; out_ready = 1 -> drain and next accept same cycle.
REQ-030 rst_n = 0 for one cycle after row 3 accepted, packet held -> out_valid = 0 next cycle; only frow1_ready may rise afterwards.

Source files
------------

// File: rtl/special_merge_pkg.sv
// special_pkg: shared types and constants for the special_merge block.
//   state_t   - sequencing FSM states (filter rows vs. ifmap packets)
//   ROW_*     - encodings carried on out_filter_row
//   next_row  - successor of a filter row index, wrapping after the last row
package special_pkg;

    typedef enum logic {
        S_FILTER = 1'b0,
        S_IFMAP  = 1'b1
    } state_t;

    localparam logic [2:0] ROW_NONE  = 3'b000;
    localparam logic [2:0] ROW_FIRST = 3'b001;
    localparam logic [2:0] ROW_LAST  = 3'b101;

    function automatic logic [2:0] next_row(input logic [2:0] row);
        return (row == ROW_LAST) ? ROW_FIRST : row + 3'd1;
    endfunction

endpackage

// File: rtl/special_merge_if.sv
// special_merge_if: bundle of all valid/ready channels around special_merge.
//   frow1..frow5 : filter row channels, 5*FILTER_WIDTH bit payload
//   ifmap        : ifmap channel (25 bit data, conv location, 2 bit size)
//   out          : merged packet channel with filter/ifmap flag and row tag
// modport master = traffic source/sink side, modport slave = the merger.
interface special_merge_if #(
    parameter int FILTER_WIDTH = 8
);
    localparam int PW = 5 * FILTER_WIDTH;
    localparam int LW = PW - 27;

    logic          frow1_valid;
    logic          frow1_ready;
    logic [PW-1:0] frow1_data;
    logic          frow2_valid;
    logic          frow2_ready;
    logic [PW-1:0] frow2_data;
    logic          frow3_valid;
    logic          frow3_ready;
    logic [PW-1:0] frow3_data;
    logic          frow4_valid;
    logic          frow4_ready;
    logic [PW-1:0] frow4_data;
    logic          frow5_valid;
    logic          frow5_ready;
    logic [PW-1:0] frow5_data;

    logic          ifmap_valid;
    logic          ifmap_ready;
    logic [24:0]   ifmap_data;
    logic [LW-1:0] ifmap_conv_loc;
    logic [1:0]    ifmap_size;

    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          out_ifmapb_filter;
    logic [2:0]    out_filter_row;

    modport master (
        output frow1_valid, frow1_data, input frow1_ready,
        output frow2_valid, frow2_data, input frow2_ready,
        output frow3_valid, frow3_data, input frow3_ready,
        output frow4_valid, frow4_data, input frow4_ready,
        output frow5_valid, frow5_data, input frow5_ready,
        output ifmap_valid, ifmap_data, ifmap_conv_loc, ifmap_size,
        input  ifmap_ready,
        input  out_valid, out_data, out_ifmapb_filter, out_filter_row,
        output out_ready
    );

    modport slave (
        input  frow1_valid, frow1_data, output frow1_ready,
        input  frow2_valid, frow2_data, output frow2_ready,
        input  frow3_valid, frow3_data, output frow3_ready,
        input  frow4_valid, frow4_data, output frow4_ready,
        input  frow5_valid, frow5_data, output frow5_ready,
        input  ifmap_valid, ifmap_data, ifmap_conv_loc, ifmap_size,
        output ifmap_ready,
        output out_valid, out_data, out_ifmapb_filter, out_filter_row,
        input  out_ready
    );

endinterface

// File: rtl/special_merge_out_reg.sv
// pkt_out_reg: one-entry valid/ready output register.
//   clk, rst_n        - clock, synchronous active-low reset
//   in_valid/in_ready - upstream handshake; in_ready never depends on in_valid
//   in_data           - packet to capture
//   out_valid/out_ready/out_data - downstream handshake and held packet
// A drain and a new capture in the same cycle replace the entry without a
// bubble; with out_ready low the entry is frozen and upstream is blocked.
module pkt_out_reg #(
    parameter int WIDTH = 44
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Ready is held low during reset so nothing is accepted into a register
    // that is being cleared.
    assign in_ready  = rst_n && (!valid_reg || out_ready);
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/special_merge.sv
// special_merge: merges five filter-row channels and one ifmap channel into a
// single tagged packet stream.  Rows are taken strictly in order 1..5, then
// IFMAP_PER_FILTER ifmap packets, then the cycle repeats.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - special_merge_if slave modport (all channels)
// Output packet = {payload, ifmapb_filter, filter_row}; ifmap payload is
// {ifmap_data, ifmap_conv_loc, ifmap_size}.
module special_merge
    import special_pkg::*;
#(
    parameter int FILTER_WIDTH     = 8,
    parameter int IFMAP_PER_FILTER = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    special_merge_if.slave       bus
);
    localparam int PW  = 5 * FILTER_WIDTH;
    localparam int PKW = PW + 4;
    localparam logic [7:0] CNT_LAST = 8'(IFMAP_PER_FILTER - 1);

    state_t     state_reg, state_next;
    logic [2:0] row_idx_reg, row_idx_next;
    logic [7:0] ifmap_cnt_reg, ifmap_cnt_next;

    logic [4:0]    frow_valid;
    logic [4:0]    frow_ready;
    logic [4:0]    row_fire;
    logic [PW-1:0] frow_data [5];

    logic           can_accept;
    logic           ifmap_fire;
    logic           pkt_valid;
    logic [PKW-1:0] pkt_in;
    logic [PKW-1:0] pkt_out;
    logic           out_valid_w;

    assign frow_valid = {bus.frow5_valid, bus.frow4_valid, bus.frow3_valid,
                         bus.frow2_valid, bus.frow1_valid};
    assign frow_data[0] = bus.frow1_data;
    assign frow_data[1] = bus.frow2_data;
    assign frow_data[2] = bus.frow3_data;
    assign frow_data[3] = bus.frow4_data;
    assign frow_data[4] = bus.frow5_data;

    assign bus.frow1_ready = frow_ready[0];
    assign bus.frow2_ready = frow_ready[1];
    assign bus.frow3_ready = frow_ready[2];
    assign bus.frow4_ready = frow_ready[3];
    assign bus.frow5_ready = frow_ready[4];

    // Readies are built only from state and the output register's ability to
    // take a packet, so no valid ever loops back to its own ready.  Rows that
    // arrive early simply see ready low until their turn.
    for (genvar gi = 0; gi < 5; gi++) begin : g_row
        assign frow_ready[gi] = can_accept && (state_reg == S_FILTER) &&
                                (row_idx_reg == 3'(gi + 1));
        assign row_fire[gi]   = frow_valid[gi] && frow_ready[gi];
    end

    assign bus.ifmap_ready = can_accept && (state_reg == S_IFMAP);
    assign ifmap_fire      = bus.ifmap_valid && bus.ifmap_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_FILTER;
            row_idx_reg   <= ROW_FIRST;
            ifmap_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            row_idx_reg   <= row_idx_next;
            ifmap_cnt_reg <= ifmap_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_idx_next   = row_idx_reg;
        ifmap_cnt_next = ifmap_cnt_reg;
        pkt_valid      = 1'b0;
        pkt_in         = '0;

        case (state_reg)
            S_FILTER: begin
                // At most one row_fire bit can be set: only the current row
                // has its ready asserted.
                for (int k = 0; k < 5; k++) begin
                    if (row_fire[k]) begin
                        pkt_valid = 1'b1;
                        pkt_in    = {frow_data[k], 1'b1, row_idx_reg};
                    end
                end
                if (pkt_valid) begin
                    row_idx_next = next_row(row_idx_reg);
                    if (row_idx_reg == ROW_LAST) begin
                        state_next     = S_IFMAP;
                        ifmap_cnt_next = '0;
                    end
                end
            end
            S_IFMAP: begin
                if (ifmap_fire) begin
                    pkt_valid = 1'b1;
                    pkt_in    = {bus.ifmap_data, bus.ifmap_conv_loc,
                                 bus.ifmap_size, 1'b0, ROW_NONE};
                    if (ifmap_cnt_reg == CNT_LAST) begin
                        state_next     = S_FILTER;
                        ifmap_cnt_next = '0;
                        row_idx_next   = ROW_FIRST;
                    end else begin
                        ifmap_cnt_next = ifmap_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = S_FILTER;
            end
        endcase
    end

    pkt_out_reg #(
        .WIDTH(PKW)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pkt_valid),
        .in_ready  (can_accept),
        .in_data   (pkt_in),
        .out_valid (out_valid_w),
        .out_ready (bus.out_ready),
        .out_data  (pkt_out)
    );

    assign bus.out_valid = out_valid_w;
    assign {bus.out_data, bus.out_ifmapb_filter, bus.out_filter_row} = pkt_out;

endmodule
